// File: rtl/ucie_clk_hs_ds_rsp_if.sv
// ucie_clk_hs_ds_rsp_if -- handshake bundle for the downstream clock/wake
// responder. The signal names keep the block's pin names.
//   clk_req_i / clk_ack_o    : 4-phase clock request / acknowledge (upstream)
//   wake_req_o / wake_ack_i  : 4-phase wake request / acknowledge (upstream)
//   wake_start_i             : local single-cycle wake request pulse
//   wake_done_o              : single-cycle wake complete pulse
//   clk_en_o                 : local clock-gate enable
//   gate_ok_i                : local logic idle, clock removal permitted
//   timeout_o                : sticky wake timeout flag
// Modports: slave = the responder, master = upstream/local environment.
interface ucie_clk_hs_ds_rsp_if;
  logic clk_req_i;
  logic clk_ack_o;
  logic wake_req_o;
  logic wake_ack_i;
  logic wake_start_i;
  logic wake_done_o;
  logic clk_en_o;
  logic gate_ok_i;
  logic timeout_o;

  modport slave (
    input  clk_req_i, wake_ack_i, wake_start_i, gate_ok_i,
    output clk_ack_o, wake_req_o, wake_done_o, clk_en_o, timeout_o
  );

  modport master (
    output clk_req_i, wake_ack_i, wake_start_i, gate_ok_i,
    input  clk_ack_o, wake_req_o, wake_done_o, clk_en_o, timeout_o
  );
endinterface

// File: rtl/ucie_clk_hs_ds_rsp.sv
// ucie_clk_hs_ds_rsp -- downstream responder for the UCIe clock handshake
// plus a local wake handshake toward upstream.
// Ports:
//   clk_i    : single clock, rising edge
//   rstn_i   : asynchronous active-low reset
//   swrst_i  : synchronous active-high soft reset (same effect as rstn_i)
//   hs       : ucie_clk_hs_ds_rsp_if.slave handshake bundle
// Parameters:
//   ACK_DLY  : cycles from clk_en_o rise to clk_ack_o rise (1..15)
//   WAKE_TO  : wake-ack timeout in cycles (1..65535)
// Build option: define UCIE_HS_DS_WAKE_TIMEOUT_EN to enable the wake-ack
// timeout; otherwise W_REQ waits indefinitely and timeout_o is tied low.
//
// state    | meaning
// C_IDLE   | clock gated, no ack
// C_UNGATE | clock enabled, counting ACK_DLY before ack
// C_ACTIVE | clock enabled and acknowledged
// W_IDLE   | no wake in flight
// W_REQ    | wake_req_o high, waiting for wake_ack_i
// W_REL    | wake_req_o dropped, waiting for wake_ack_i to fall
module ucie_clk_hs_ds_rsp #(
  parameter int unsigned ACK_DLY = 4,
  parameter int unsigned WAKE_TO = 255
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   swrst_i,
  ucie_clk_hs_ds_rsp_if.slave    hs
);

  typedef enum logic [1:0] {C_IDLE, C_UNGATE, C_ACTIVE} c_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_REL} w_state_t;

  // Down-counter loads N-1 on entry; terminal count 0 is the Nth cycle.
  localparam logic [3:0] ACK_LOAD = 4'(ACK_DLY - 1);

  c_state_t   c_state;
  logic [3:0] ack_cnt;
  logic       clk_en;
  logic       clk_ack;

  w_state_t   w_state;
  logic       wake_req;
  logic       wake_done;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      c_state <= C_IDLE;
      ack_cnt <= '0;
      clk_en  <= 1'b0;
      clk_ack <= 1'b0;
    end else if (swrst_i) begin
      c_state <= C_IDLE;
      ack_cnt <= '0;
      clk_en  <= 1'b0;
      clk_ack <= 1'b0;
    end else begin
      case (c_state)
        C_IDLE: begin
          if (hs.clk_req_i) begin
            c_state <= C_UNGATE;
            ack_cnt <= ACK_LOAD;
            clk_en  <= 1'b1;
          end
        end
        // A request withdrawn here is not aborted: the ack must still be
        // given so the 4-phase sequence stays ordered.
        C_UNGATE: begin
          if (ack_cnt == 4'd0) begin
            c_state <= C_ACTIVE;
            clk_ack <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt - 4'd1;
          end
        end
        C_ACTIVE: begin
          if (!hs.clk_req_i && hs.gate_ok_i) begin
            c_state <= C_IDLE;
            clk_en  <= 1'b0;
            clk_ack <= 1'b0;
          end
        end
        default: begin
          c_state <= C_IDLE;
          clk_en  <= 1'b0;
          clk_ack <= 1'b0;
        end
      endcase
    end
  end

`ifdef UCIE_HS_DS_WAKE_TIMEOUT_EN
  localparam logic [15:0] WAKE_LOAD = 16'(WAKE_TO - 1);
  logic [15:0] wake_cnt;
  logic        timeout;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state   <= W_IDLE;
      wake_req  <= 1'b0;
      wake_done <= 1'b0;
`ifdef UCIE_HS_DS_WAKE_TIMEOUT_EN
      wake_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else if (swrst_i) begin
      w_state   <= W_IDLE;
      wake_req  <= 1'b0;
      wake_done <= 1'b0;
`ifdef UCIE_HS_DS_WAKE_TIMEOUT_EN
      wake_cnt  <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      wake_done <= 1'b0;
      case (w_state)
        W_IDLE: begin
          // Clock already present or being requested: nothing to wake.
          if (hs.wake_start_i) begin
            if (c_state == C_IDLE && !hs.clk_req_i) begin
              w_state  <= W_REQ;
              wake_req <= 1'b1;
`ifdef UCIE_HS_DS_WAKE_TIMEOUT_EN
              wake_cnt <= WAKE_LOAD;
`endif
            end else begin
              wake_done <= 1'b1;
            end
          end
        end
        W_REQ: begin
          if (hs.wake_ack_i) begin
            w_state  <= W_REL;
            wake_req <= 1'b0;
          end
`ifdef UCIE_HS_DS_WAKE_TIMEOUT_EN
          else if (wake_cnt == 16'd0) begin
            w_state  <= W_IDLE;
            wake_req <= 1'b0;
            timeout  <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt - 16'd1;
          end
`endif
        end
        W_REL: begin
          if (!hs.wake_ack_i) begin
            w_state   <= W_IDLE;
            wake_done <= 1'b1;
          end
        end
        default: begin
          w_state  <= W_IDLE;
          wake_req <= 1'b0;
        end
      endcase
    end
  end

  assign hs.clk_en_o    = clk_en;
  assign hs.clk_ack_o   = clk_ack;
  assign hs.wake_req_o  = wake_req;
  assign hs.wake_done_o = wake_done;
`ifdef UCIE_HS_DS_WAKE_TIMEOUT_EN
  assign hs.timeout_o   = timeout;
`else
  assign hs.timeout_o   = 1'b0;
`endif

endmodule
